// File: rtl/vis_packetiser_pkg.sv
// vis_packetiser_pkg: shared state encoding, default header and byte-count helper
// for the visibility packetiser.
`default_nettype none

package vis_packetiser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAG0  = 3'd1,
    ST_MAG1  = 3'd2,
    ST_SEQN  = 3'd3,
    ST_FETCH = 3'd4,
    ST_DATA  = 3'd5,
    ST_CSUM  = 3'd6
  } vis_pkt_state_t;

  localparam logic [15:0] MAGIC_DEFAULT = 16'h5456;

  function automatic int nbytes(input int accum);
    return (2 * accum) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vis_packetiser.sv
// vis_packetiser: frames correlator visibility words into byte packets
// (magic, sequence, little-endian payload, XOR checksum with tlast).
`default_nettype none

module vis_packetiser
  import vis_packetiser_pkg::*;
#(
  parameter int          ACCUM     = 32,
  parameter int          MAX_WORDS = 576,
  parameter logic [15:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [ACCUM-1:0] s_revis,
  input  logic [ACCUM-1:0] s_imvis,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [7:0]       m_tdata,
  output logic [7:0]       seq_o,
  output logic             busy_o,
  output logic             trunc_o
);

  localparam int NB = nbytes(ACCUM);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = $clog2(MAX_WORDS + 1);

  vis_pkt_state_t      state_q;
  logic [2*ACCUM-1:0]  sr_q;
  logic [IW-1:0]       idx_q;
  logic [WW-1:0]       wcnt_q;
  logic [7:0]          csum_q;
  logic [7:0]          seq_q;
  logic                last_q;
  logic                s_tready_q;
  logic                m_tvalid_q;
  logic                m_tlast_q;
  logic [7:0]          m_tdata_q;
  logic                busy_q;
  logic                trunc_q;

  // Outputs are loaded together with the state they belong to, so every
  // output is a flop and nothing from s_* or m_tready reaches a port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      csum_q     <= '0;
      seq_q      <= '0;
      last_q     <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      busy_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_tvalid) begin
            state_q    <= ST_MAG0;
            busy_q     <= 1'b1;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= MAGIC[15:8];
          end
        end
        ST_MAG0: begin
          if (m_tready) begin
            state_q   <= ST_MAG1;
            m_tdata_q <= MAGIC[7:0];
          end
        end
        ST_MAG1: begin
          if (m_tready) begin
            state_q   <= ST_SEQN;
            m_tdata_q <= seq_q;
          end
        end
        ST_SEQN: begin
          if (m_tready) begin
            state_q    <= ST_FETCH;
            csum_q     <= seq_q;
            wcnt_q     <= '0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (s_tvalid) begin
            state_q    <= ST_DATA;
            sr_q       <= {s_imvis, s_revis};
            last_q     <= s_tlast;
            idx_q      <= '0;
            wcnt_q     <= wcnt_q + WW'(1);
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_revis[7:0];
          end
        end
        ST_DATA: begin
          if (m_tready) begin
            csum_q <= csum_q ^ sr_q[7:0];
            sr_q   <= sr_q >> 8;
            idx_q  <= idx_q + IW'(1);
            if (idx_q == IW'(NB - 1)) begin
              if (last_q || (wcnt_q == WW'(MAX_WORDS))) begin
                state_q   <= ST_CSUM;
                m_tdata_q <= csum_q ^ sr_q[7:0];
                m_tlast_q <= 1'b1;
              end else begin
                state_q    <= ST_FETCH;
                m_tvalid_q <= 1'b0;
                s_tready_q <= 1'b1;
              end
            end else begin
              m_tdata_q <= sr_q[15:8];
            end
          end
        end
        ST_CSUM: begin
          if (m_tready) begin
            state_q    <= ST_IDLE;
            seq_q      <= seq_q + 8'd1;
            trunc_q    <= !last_q;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          s_tready_q <= 1'b0;
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;
  assign seq_o    = seq_q;
  assign busy_o   = busy_q;
  assign trunc_o  = trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_vis_packetiser.sv
// tb_vis_packetiser: directed vectors and corner-case sequences for the
// visibility packetiser, with a byte-stream reference model.
`default_nettype none

module tb_vis_packetiser;

  localparam int ACCUM = 32;
  localparam int MAXW  = 4;
  localparam int NB    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [31:0] s_revis = '0;
  logic [31:0] s_imvis = '0;
  logic        m_tready = 1'b1;
  logic        s_tready, m_tvalid, m_tlast, busy_o, trunc_o;
  logic [7:0]  m_tdata, seq_o;

  vis_packetiser #(.ACCUM(ACCUM), .MAX_WORDS(MAXW), .MAGIC(16'h5456)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_revis(s_revis), .s_imvis(s_imvis),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .seq_o(seq_o), .busy_o(busy_o), .trunc_o(trunc_o)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [8:0] got_q[$];
  int         cyc_q[$];
  logic [8:0] exp_q[$];
  int         trunc_cnt = 0;
  int         n_consumed = 0;
  int         exp_trunc = 0;
  bit         rdy_rand = 1'b0;
  logic [7:0] m_seq = 8'd0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [7:0]  seq;
    logic [7:0]  csum;
  } vec_t;
  vec_t vt[5];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_stall)
        check(m_tvalid && ({m_tlast, m_tdata} == prev_out), "stall_hold",
              {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_out});
      if (s_tready)
        check(!m_tvalid && busy_o, "tready_only_fetch", {30'd0, m_tvalid, busy_o}, 32'd1);
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        cyc_q.push_back(cyc);
      end
      if (trunc_o) trunc_cnt++;
      if (s_tvalid && s_tready) n_consumed++;
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      m_tready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  function automatic logic [63:0] word_of(input int f, input int i);
    logic [31:0] re, im;
    re = 32'(f) * 32'h00010001 + 32'(i) * 32'h11111111;
    im = (32'(f) * 32'h01000193) ^ (32'(i) * 32'h9E3779B9);
    return {im, re};
  endfunction

  // Reference model: splits a frame into packets of at most MAXW words.
  task automatic push_frame(input int f, input int nw);
    int i = 0;
    while (i < nw) begin
      logic [7:0]  cs;
      logic [63:0] w;
      int k = 0;
      exp_q.push_back({1'b0, 8'h54});
      exp_q.push_back({1'b0, 8'h56});
      exp_q.push_back({1'b0, m_seq});
      cs = m_seq;
      while (k < MAXW && i < nw) begin
        w = word_of(f, i);
        for (int b = 0; b < NB; b++) begin
          exp_q.push_back({1'b0, w[8*b +: 8]});
          cs = cs ^ w[8*b +: 8];
        end
        k++;
        i++;
      end
      exp_q.push_back({1'b1, cs});
      if (i < nw) exp_trunc++;
      m_seq = m_seq + 8'd1;
    end
  endtask

  task automatic send_word(input logic [31:0] re, input logic [31:0] im, input bit last);
    int n = 0;
    s_revis  = re;
    s_imvis  = im;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clock);
    while (!s_tready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (!s_tready) begin
      check(1'b0, "src_timeout", n, 0);
      s_tvalid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input int f, input int nw, input bit keep);
    logic [63:0] w;
    for (int i = 0; i < nw; i++) begin
      w = word_of(f, i);
      send_word(w[31:0], w[63:32], i == nw - 1);
    end
    if (!keep) s_tvalid = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete();
    cyc_q.delete();
    exp_q.delete();
    trunc_cnt  = 0;
    exp_trunc  = 0;
    n_consumed = 0;
  endtask

  task automatic drain_compare(input string name);
    int n = 0;
    int bad = -1;
    while (!(got_q.size() >= exp_q.size() && !busy_o) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    #1;
    if (got_q.size() != exp_q.size()) begin
      check(1'b0, {name, "_len"}, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        $display("  %s first difference at byte %0d", name, bad);
        check(1'b0, name, got_q[bad], exp_q[bad]);
      end else begin
        check(1'b1, name, 0, 0);
      end
    end
  endtask

  task automatic check_gaps(input string name);
    int bad = 0;
    int sz = got_q.size();
    for (int i = 0; i + 1 < sz; i++)
      if (got_q[i][8] && (cyc_q[i+1] - cyc_q[i] != 2)) bad++;
    check(bad == 0, name, bad, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_seq = 8'd0;
  endtask

  initial begin
    vt[0] = '{re: 32'h04030201, im: 32'h08070605, seq: 8'h00, csum: 8'h08};
    vt[1] = '{re: 32'h00000000, im: 32'h00000000, seq: 8'h01, csum: 8'h01};
    vt[2] = '{re: 32'hFFFFFFFF, im: 32'hFFFFFFFF, seq: 8'h02, csum: 8'h02};
    vt[3] = '{re: 32'h000000A5, im: 32'h5A000000, seq: 8'h03, csum: 8'hFC};
    vt[4] = '{re: 32'h12345678, im: 32'h9ABCDEF0, seq: 8'h04, csum: 8'h04};

    repeat (3) @(negedge clock);
    check({s_tready, m_tvalid, m_tlast, busy_o, trunc_o} == 5'd0, "reset_ctrl",
          {s_tready, m_tvalid, m_tlast, busy_o, trunc_o}, 0);
    check(m_tdata == 8'd0, "reset_tdata", m_tdata, 0);
    check(seq_o == 8'd0, "reset_seq", seq_o, 0);
    reset = 1'b0;
    m_seq = 8'd0;
    @(negedge clock);

    // Single-word frames with hand-computed checksums.
    for (int v = 0; v < 5; v++) begin
      logic [63:0] w;
      clear_q();
      w = {vt[v].im, vt[v].re};
      exp_q.push_back({1'b0, 8'h54});
      exp_q.push_back({1'b0, 8'h56});
      exp_q.push_back({1'b0, vt[v].seq});
      for (int b = 0; b < NB; b++) exp_q.push_back({1'b0, w[8*b +: 8]});
      exp_q.push_back({1'b1, vt[v].csum});
      send_word(vt[v].re, vt[v].im, 1'b1);
      s_tvalid = 1'b0;
      drain_compare("vec_stream");
      check(seq_o == 8'(vt[v].seq + 8'd1), "vec_seq_after", seq_o, 8'(vt[v].seq + 8'd1));
      if (v == 0) begin
        if (cyc_q.size() == 12) begin
          check(cyc_q[3] - cyc_q[0] == 4, "lat_first_payload", cyc_q[3] - cyc_q[0], 4);
          check(cyc_q[11] - cyc_q[0] == 12, "lat_csum", cyc_q[11] - cyc_q[0], 12);
        end else begin
          check(1'b0, "lat_bytes", cyc_q.size(), 12);
        end
      end
    end
    m_seq = 8'd5;

    // s_tvalid held high across CSUM/IDLE between back-to-back frames.
    clear_q();
    push_frame(10, 1);
    push_frame(11, 3);
    push_frame(12, 2);
    send_frame(10, 1, 1'b1);
    send_frame(11, 3, 1'b1);
    send_frame(12, 2, 1'b0);
    drain_compare("hold_stream");
    check(n_consumed == 6, "hold_consumed", n_consumed, 6);
    check_gaps("hold_idle_gap");

    // Random back-pressure on a 16-word frame (splits into 4 packets).
    clear_q();
    rdy_rand = 1'b1;
    push_frame(20, 16);
    send_frame(20, 16, 1'b0);
    drain_compare("bp_stream");
    rdy_rand = 1'b0;
    check(trunc_cnt == exp_trunc, "bp_trunc", trunc_cnt, exp_trunc);

    // Reset during the payload; outputs must clear without a clock edge.
    clear_q();
    begin
      logic [63:0] w;
      int n = 0;
      w = word_of(30, 0);
      s_revis  = w[31:0];
      s_imvis  = w[63:32];
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      while (got_q.size() < 6 && n < 1000) begin
        @(negedge clock);
        #1;
        n++;
      end
      check(got_q.size() >= 6, "mid_reset_reach", got_q.size(), 6);
      #1;
      reset = 1'b1;
      #1;
      check({s_tready, m_tvalid, m_tlast, busy_o, trunc_o, m_tdata, seq_o} == 21'd0,
            "async_reset", {s_tready, m_tvalid, m_tlast, busy_o, trunc_o, m_tdata, seq_o}, 0);
      s_tvalid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      m_seq = 8'd0;
    end
    clear_q();
    push_frame(31, 1);
    send_frame(31, 1, 1'b0);
    drain_compare("post_reset_stream");
    if (got_q.size() >= 3)
      check(got_q[0] == 9'h054 && got_q[1] == 9'h056 && got_q[2] == 9'h000, "post_reset_hdr",
            {got_q[0][7:0], got_q[1][7:0], got_q[2][7:0]}, 32'h545600);
    else
      check(1'b0, "post_reset_hdr_len", got_q.size(), 3);

    // Forced split: 6 words with MAX_WORDS=4.
    do_reset();
    clear_q();
    push_frame(40, 6);
    send_frame(40, 6, 1'b0);
    drain_compare("split_stream");
    check(trunc_cnt == 1, "split_trunc", trunc_cnt, 1);
    check(got_q.size() == 56, "split_len", got_q.size(), 56);
    if (got_q.size() == 56) begin
      check(got_q[35] == {1'b1, got_q[35][7:0]} && got_q[2] == 9'h000, "split_pktA",
            {got_q[35][8], got_q[2]}, 32'h200);
      check(got_q[38] == 9'h001 && got_q[55][8], "split_pktB", {got_q[55][8], got_q[38]}, 32'h201);
    end

    // Sequence wrap over 257 consecutive one-word frames.
    do_reset();
    clear_q();
    for (int f = 0; f <= 256; f++) push_frame(100 + f, 1);
    for (int f = 0; f <= 256; f++) send_frame(100 + f, 1, f < 256);
    drain_compare("wrap_stream");
    check_gaps("wrap_idle_gap");
    if (got_q.size() == 257 * 12) begin
      check(got_q[255*12+2] == 9'h0FF, "wrap_seq_ff", got_q[255*12+2], 9'h0FF);
      check(got_q[256*12+2] == 9'h000, "wrap_seq_00", got_q[256*12+2], 9'h000);
    end else begin
      check(1'b0, "wrap_len", got_q.size(), 257 * 12);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vis_packetiser.md
# vis_packetiser

Frames visibility words from the correlator's bus-side output (real/imaginary pairs with valid/ready/last) into a byte-wide AXI-stream for the USB bulk-IN endpoint. Each correlator frame becomes one packet: a magic header, an 8-bit sequence number, the little-endian visibility payload, and an XOR checksum byte carrying `tlast`. The block sits between the correlator bus port and the USB/DDR3 byte streams, in the bus clock domain.

## Interface

**Parameters**
- `ACCUM`, 32: bits per visibility component. Must be a multiple of 8.
- `MAX_WORDS`, 576: maximum visibility words per packet before a forced split.
- `MAGIC`, 16'h5456: header value, sent MSB first ("TV").

**Ports**
- `clock`, in, 1: bus clock. All logic is in this domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_tvalid`, in, 1: visibility word valid.
- `s_tready`, out, 1: visibility word accepted.
- `s_tlast`, in, 1: last word of the correlator frame.
- `s_revis`, in, ACCUM: real component.
- `s_imvis`, in, ACCUM: imaginary component.
- `m_tvalid`, out, 1: byte valid.
- `m_tready`, in, 1: downstream ready.
- `m_tlast`, out, 1: last byte of the packet (the checksum byte).
- `m_tdata`, out, 8: byte.
- `seq_o`, out, 8: sequence number of the next or current packet.
- `busy_o`, out, 1: high whenever state ≠ IDLE.
- `trunc_o`, out, 1: one-cycle pulse when a packet is force-split at `MAX_WORDS`.

## Operation

- `NB = 2*ACCUM/8` bytes per word. Shift register `sr = {s_imvis, s_revis}` is sent LSB byte first, so the real component goes out before the imaginary one.
- States are IDLE, MAG0, MAG1, SEQN, FETCH, DATA, CSUM.
- **IDLE:** `m_tvalid=0`, `s_tready=0`. When `s_tvalid=1`, go to MAG0. No input word is consumed here.
- **MAG0 / MAG1:** `m_tvalid=1`, `m_tdata=MAGIC[15:8]` then `MAGIC[7:0]`. Advance on `m_tready`.
- **SEQN:** `m_tdata=seq`. On transfer, `csum<=seq`, `wcnt<=0`, go to FETCH.
- **FETCH:** `m_tvalid=0`, `s_tready=1`. On `s_tvalid`:
  - latch `sr`, `last_q<=s_tlast`, `idx<=0`, `wcnt<=wcnt+1`;
  - go to DATA.
- **DATA:** `m_tdata=sr[7:0]`. On transfer:
  - `csum<=csum^sr[7:0]`, `sr<=sr>>8`, `idx<=idx+1`;
  - when `idx==NB-1`, go to CSUM if `last_q` or `wcnt==MAX_WORDS`, otherwise go to FETCH.
- **CSUM:** `m_tdata=csum`, `m_tlast=1`. On transfer:
  - `seq<=seq+1` (mod 256);
  - pulse `trunc_o` if `!last_q`;
  - go to IDLE.
- A forced split does not drop words. The next word starts a new packet with `seq+1`.
- `csum` is the XOR of the sequence byte and every payload byte. Magic bytes are excluded.

## Timing

- **Reset values:**
  - state=IDLE; `s_tready`, `m_tvalid`, `m_tlast`, `busy_o` and `trunc_o` are 0;
  - `m_tdata=0`, `seq_o=0`, `csum=0`.
- **Registered outputs:** all outputs are decoded from registered state only. There is no combinational path from `s_*` or `m_tready` to any output.
- **AXI rules:**
  - `m_tvalid` stays high with stable `m_tdata`/`m_tlast` until `m_tready`;
  - `s_tready` is asserted only in FETCH, independent of `s_tvalid`.
- **Latency with `m_tready` held at 1:**
  - `s_tvalid` sampled in IDLE at cycle 0;
  - MAG0 byte at cycle 1, MAG1 at cycle 2, SEQN at cycle 3;
  - FETCH at cycle 4, first payload byte at cycle 5.
- **Throughput:** NB+1 cycles per word; the packet-close CSUM cycle is extra.
- **Packet length:** exactly `4 + NB*words` bytes.
- **Reset mid-packet:** the packet is abandoned with no `tlast`, and `seq` returns to 0. Downstream flushes on its own reset.
- **Input after a close:** `s_tvalid` high during CSUM is not consumed. IDLE re-enters MAG0 on the next cycle.
- **Back-to-back packets:** one idle cycle (IDLE) separates each CSUM from the next MAG0.

## Structure

- The shared package holds:
  - the state enum `vis_pkt_state_t`;
  - `MAGIC_DEFAULT`;
  - the byte-count function `nbytes(accum)`.
- Single module, no sub-modules. The shift register and checksum are inline.
- A clock-domain-crossing `axis_afifo` toward the USB clock is instantiated outside this block.

## Test plan

1. **Single-word frame.** `ACCUM=32`, `revis=32'h04030201`, `imvis=32'h08070605`, `s_tlast=1`, `m_tready=1` → 12 bytes `54 56 00 01 02 03 04 05 06 07 08 08`, with `tlast` only on the 12th byte and `seq_o` becoming 1.
2. **Back-pressure.** Random 30%-duty `m_tready` on 16-word frames → byte sequence identical to the `m_tready=1` run, and `m_tdata`/`m_tvalid` never change while stalled.
3. **Sequence wrap.** 257 consecutive one-word frames → sequence bytes 00..FF then 00, with one IDLE cycle between packets.
4. **Forced split.** `MAX_WORDS=4`, 6-word frame with `s_tlast` only on word 6 → packet A has 4 words, seq 00, `tlast`, and one `trunc_o` pulse; packet B has 2 words, seq 01, no `trunc_o`; no word is lost.
5. **Reset mid-packet.** Assert `reset` during DATA byte 3 → outputs 0 immediately (asynchronously); the next frame starts with `54 56 00`.
6. **Input hold.** `s_tvalid` held high across CSUM/IDLE → `s_tready` is seen only in FETCH, and each word is consumed exactly once (scoreboard compare).
